// File: rtl/seg7_pattern_decoder.sv
// seg7_pattern_decoder
// Receive-side decoder for seven-segment display lines. Each sampled pattern
// must stay identical for STABLE_CYCLES consecutive register samples before
// it is locked. A locked pattern is then decoded back to its hex digit, or
// flagged as blank (all segments off) or illegal.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         decoder enable; low forces the FSM to IDLE
//   a..g       segment lines, active-high, synchronous to clk (a = MSB)
//   hex_out    last locked legal digit
//   valid      one-cycle pulse when a legal digit locks
//   blank      level: last locked pattern was all-off
//   err        level: last locked pattern was illegal
//   lock_cnt   count of legal-digit lock events (wraps at 255)
`timescale 1ns/1ps
module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4  // legal range 2..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] hex_out,
    output logic       valid,
    output logic       blank,
    output logic       err,
    output logic [7:0] lock_cnt
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        LOCKED
    } state_t;

    state_t     state;
    logic [6:0] seg_d;
    logic [6:0] seg_q;
    logic [6:0] cand;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       dec_legal;
    logic [3:0] dec_digit;

    assign seg_d   = {a, b, c, d, e, f, g};
    assign cnt_inc = cnt + 4'd1;

    // Decode the candidate pattern. At the lock edge cand equals seg_q, so
    // decoding cand gives the digit of the pattern being locked.
    always_comb begin
        dec_legal = 1'b1;
        dec_digit = 4'h0;
        case (cand)
            7'h7E: dec_digit = 4'h0;
            7'h30: dec_digit = 4'h1;
            7'h6D: dec_digit = 4'h2;
            7'h79: dec_digit = 4'h3;
            7'h33: dec_digit = 4'h4;
            7'h5B: dec_digit = 4'h5;
            7'h5F: dec_digit = 4'h6;
            7'h70: dec_digit = 4'h7;
            7'h7F: dec_digit = 4'h8;
            7'h7B: dec_digit = 4'h9;
            7'h77: dec_digit = 4'hA;
            7'h1F: dec_digit = 4'hB;
            7'h4E: dec_digit = 4'hC;
            7'h3D: dec_digit = 4'hD;
            7'h4F: dec_digit = 4'hE;
            7'h47: dec_digit = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            seg_q    <= '0;
            cand     <= '0;
            cnt      <= '0;
            hex_out  <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            blank    <= 1'b1;
            lock_cnt <= '0;
        end else begin
            seg_q <= seg_d;
            valid <= 1'b0;
            // Disable takes priority over everything, including a lock that
            // would otherwise happen on this same edge.
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SETTLE;
                        cand  <= seg_q;
                        cnt   <= 4'd1;
                    end
                    SETTLE: begin
                        if (seg_q != cand) begin
                            cand <= seg_q;
                            cnt  <= 4'd1;
                        end else if (cnt_inc == STABLE_LIM) begin
                            state <= LOCKED;
                            cnt   <= cnt_inc;
                            if (cand == '0) begin
                                blank <= 1'b1;
                                err   <= 1'b0;
                            end else if (dec_legal) begin
                                hex_out  <= dec_digit;
                                valid    <= 1'b1;
                                err      <= 1'b0;
                                blank    <= 1'b0;
                                lock_cnt <= lock_cnt + 8'd1;
                            end else begin
                                err   <= 1'b1;
                                blank <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOCKED: begin
                        if (seg_q != cand) begin
                            state <= SETTLE;
                            cand  <= seg_q;
                            cnt   <= 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
`timescale 1ns/1ps
module tb_seg7_pattern_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [6:0] seg;
    logic [3:0] hex_out;
    logic       valid;
    logic       blank;
    logic       err;
    logic [7:0] lock_cnt;

    seg7_pattern_decoder #(.STABLE_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a        (seg[6]),
        .b        (seg[5]),
        .c        (seg[4]),
        .d        (seg[3]),
        .e        (seg[2]),
        .f        (seg[1]),
        .g        (seg[0]),
        .hex_out  (hex_out),
        .valid    (valid),
        .blank    (blank),
        .err      (err),
        .lock_cnt (lock_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] hex;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         exp_pulses = 0;
    logic [7:0] exp_cnt = '0;
    logic       prev_valid = 1'b0;

    // Hand-written segment table for digits 0..F.
    logic [6:0] codes [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] hex);
        exp_t item;
        exp_cnt    = exp_cnt + 8'd1;
        item.hex   = hex;
        item.cnt   = exp_cnt;
        exp_q.push_back(item);
        exp_pulses++;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        seg = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        seg   = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_queue_drained", exp_q.size(), 0);
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    // Monitor: every valid pulse must match the oldest expected lock.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            pulses++;
            chk("valid_back_to_back", prev_valid, 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got hex %0h lock_cnt %0d expected no pulse at %0t",
                         hex_out, lock_cnt, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("valid_hex", hex_out, e.hex);
                chk("valid_lock_cnt", lock_cnt, e.cnt);
            end
        end
        prev_valid = rst_n && valid;
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        seg   = '0;
        repeat (2) @(negedge clk);
        chk("rst_hex", hex_out, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_blank", blank, 1);
        chk("rst_lock_cnt", lock_cnt, 0);
        rst_n = 1'b1;

        // Single lock of 5 with exact latency: valid only after edge 4.
        seg = 7'h5B;
        en  = 1'b1;
        push(4'h5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_valid_timing", valid, (i == 4) ? 1 : 0);
        end
        chk("t1_hex", hex_out, 5);
        chk("t1_lock_cnt", lock_cnt, 1);
        chk("t1_err", err, 0);
        chk("t1_blank", blank, 0);

        // Sweep all legal codes, then 256 more locks to wrap the counter.
        do_reset();
        for (int dgt = 0; dgt < 16; dgt++) begin
            push(4'(dgt));
            hold(codes[dgt], 6);
        end
        chk("sweep_lock_cnt", lock_cnt, 16);
        chk("sweep_hex", hex_out, 4'hF);
        for (int k = 0; k < 256; k++) begin
            push(k[0] ? 4'h9 : 4'h8);
            hold(k[0] ? codes[9] : codes[8], 6);
        end
        chk("wrap_lock_cnt", lock_cnt, 16);
        chk("wrap_hex", hex_out, 4'h9);

        // Short glitch to 0 then back to 3: relock of 3, never 0.
        push(4'h3);
        hold(7'h79, 6);
        chk("glitch_pre_hex", hex_out, 3);
        push(4'h3);
        hold(7'h7E, 2);
        chk("glitch_mid_hex", hex_out, 3);
        hold(7'h79, 8);
        chk("glitch_post_hex", hex_out, 3);

        // Illegal then blank patterns.
        hold(7'h01, 5);
        chk("illegal_err", err, 1);
        chk("illegal_blank", blank, 0);
        chk("illegal_hex", hex_out, 3);
        hold(7'h00, 5);
        chk("blank_blank", blank, 1);
        chk("blank_err", err, 0);
        chk("blank_hex", hex_out, 3);

        // Enable dropped mid-settle, then full requalification.
        seg = 7'h30;
        repeat (3) @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        chk("en_off_hex", hex_out, 3);
        chk("en_off_blank", blank, 1);
        chk("en_off_err", err, 0);
        en = 1'b1;
        push(4'h1);
        repeat (3) @(negedge clk);
        chk("en_requal_early_hex", hex_out, 3);
        @(negedge clk);
        chk("en_requal_hex", hex_out, 1);

        // Enable dropped exactly on the would-be lock edge.
        seg = 7'h77;
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("en_lock_edge_hex", hex_out, 1);
        en = 1'b1;
        push(4'hA);
        repeat (6) @(negedge clk);
        chk("relock_a_hex", hex_out, 4'hA);

        // Asynchronous reset while locked on A, checked before the next edge.
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_hex", hex_out, 0);
        chk("async_rst_valid", valid, 0);
        chk("async_rst_err", err, 0);
        chk("async_rst_blank", blank, 1);
        chk("async_rst_lock_cnt", lock_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seg   = '0;
        repeat (3) @(negedge clk);

        chk("queue_empty", exp_q.size(), 0);
        chk("pulse_count", pulses, exp_pulses);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
